ps2_key_serializer: RTL

- Device-side PS/2 keyboard transmitter. Converts the 11-bit ps2_key event word from hps_io into standard PS/2 scan-code set 2 serial frames on clock and data lines.
- The coco3fpga_dw PS/2 receiver consumes those lines, so keyboard input can reach the core over the native PS/2 path without hps_io's built-in clock/data emulation.
- Sits in the emu top level, on clk_sys, between hps_io and the core's ps2_clk/ps2_data inputs.

---
 rtl/ps2_key_serializer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_serializer.sv
// Device-side PS/2 keyboard transmitter: turns hps_io ps2_key toggle events into
// scan-code set 2 byte frames driven on open-collector style clock/data lines.
module ps2_key_serializer #(
  parameter int HALF_BIT   = 2000,
  parameter int GAP_CYCLES = 4000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [10:0]                   ps2_key,
  input  logic                          ps2_clk_in,
  output logic                          ps2_clk_out,
  output logic                          ps2_data_out,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [15:0] HB_LAST  = 16'(HALF_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BIT_HI, S_BIT_LO, S_GAP} state_e;

  logic              armed_q, key_prev_q, ovf_q, lo_q;
  logic [1:0]        sync_q;
  logic [2:0][7:0]   seq_buf_q, seq_buf_d;
  logic [1:0]        seq_cnt_q, seq_cnt_d, seq_len;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d, free;
  state_e            state_q, state_d;
  logic [15:0]       hcnt_q, hcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [10:0]       frm_q, frm_d;
  logic              evt, accept, push, pop, clk_s;
  logic [7:0]        head;

  assign clk_s = sync_q[1];
  assign head  = mem[rd_ptr_q];
  assign push  = (seq_cnt_q != 2'd0);

  // Event detect and enqueue sequencer: whole sequence is admitted or nothing is.
  always_comb begin
    evt       = armed_q && (ps2_key[10] != key_prev_q);
    seq_len   = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
    free      = CW'(FIFO_DEPTH) - cnt_q;
    accept    = evt && (seq_cnt_q == 2'd0) && (free >= CW'(seq_len));
    seq_buf_d = seq_buf_q;
    seq_cnt_d = seq_cnt_q;
    if (push) begin
      seq_buf_d = {8'h00, seq_buf_q[2:1]};
      seq_cnt_d = seq_cnt_q - 2'd1;
    end
    if (accept) begin
      seq_cnt_d = seq_len;
      unique case ({ps2_key[8], ~ps2_key[9]})
        2'b11:   seq_buf_d = {ps2_key[7:0], 8'hF0, 8'hE0};
        2'b10:   seq_buf_d = {8'h00, ps2_key[7:0], 8'hE0};
        2'b01:   seq_buf_d = {8'h00, ps2_key[7:0], 8'hF0};
        default: seq_buf_d = {16'h0000, ps2_key[7:0]};
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr_q] <= seq_buf_q[0];
  end

  // TX next state; the head byte is popped only after its stop bit completes.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((cnt_q != '0) && clk_s) begin
          state_d = S_BIT_HI;
          hcnt_d  = '0;
          idx_d   = '0;
          frm_d   = {1'b1, ~^head, head, 1'b0};
        end
      end
      S_BIT_HI: begin
        if (!clk_s && lo_q && (idx_q <= 4'd9)) begin
          state_d = S_GAP;
          gcnt_d  = '0;
        end else if (hcnt_q == HB_LAST) begin
          state_d = S_BIT_LO;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
      S_BIT_LO: begin
        if (hcnt_q == HB_LAST) begin
          hcnt_d = '0;
          if (idx_q == 4'd10) begin
            pop     = 1'b1;
            state_d = S_GAP;
            gcnt_d  = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_BIT_HI;
          end
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end
      default: begin
        // Gap only counts while the host leaves the clock line released.
        if (!clk_s) begin
          gcnt_d = '0;
        end else if (gcnt_q == GAP_LAST) begin
          if (cnt_q != '0) begin
            state_d = S_BIT_HI;
            hcnt_d  = '0;
            idx_d   = '0;
            frm_d   = {1'b1, ~^head, head, 1'b0};
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
    endcase
  end

  always_comb begin
    ps2_clk_out  = 1'b1;
    ps2_data_out = 1'b1;
    unique case (state_q)
      S_BIT_HI: ps2_data_out = frm_q[idx_q];
      S_BIT_LO: begin
        ps2_clk_out  = 1'b0;
        ps2_data_out = frm_q[idx_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_q    <= 1'b0;
      key_prev_q <= 1'b0;
      ovf_q      <= 1'b0;
      lo_q       <= 1'b0;
      sync_q     <= 2'b11;
      seq_buf_q  <= '0;
      seq_cnt_q  <= 2'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      hcnt_q     <= '0;
      gcnt_q     <= '0;
      idx_q      <= '0;
      frm_q      <= '1;
    end else begin
      armed_q    <= 1'b1;
      key_prev_q <= ps2_key[10];
      ovf_q      <= evt && !accept;
      sync_q     <= {sync_q[0], ps2_clk_in};
      lo_q       <= ~clk_s;
      seq_buf_q  <= seq_buf_d;
      seq_cnt_q  <= seq_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      gcnt_q     <= gcnt_d;
      idx_q      <= idx_d;
      frm_q      <= frm_d;
    end
  end

  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;
  assign busy       = (state_q != S_IDLE) || push || (cnt_q != '0);

endmodule
